// File: rtl/alu_wb_queue.sv
// In-order result queue between the integer ALU and the writeback port.
// Circular buffer with valid/ready on both sides, synchronous flush and a sticky overflow flag.
module alu_wb_queue #(
   parameter int unsigned XLEN          = 64,
   parameter int unsigned TRANS_ID_BITS = 3,
   parameter int unsigned DEPTH         = 4   // power of two, >= 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     alu_valid_i,
   output logic                     alu_ready_o,
   input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
   input  logic [XLEN-1:0]          alu_result_i,
   input  logic                     alu_branch_res_i,
   output logic                     wb_valid_o,
   input  logic                     wb_ready_i,
   output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
   output logic [XLEN-1:0]          wb_result_o,
   output logic                     wb_branch_res_o,
   output logic [$clog2(DEPTH):0]   occupancy_o,
   output logic                     overflow_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high and flush_i is low; ready never depends combinationally on the other side.
   logic [TRANS_ID_BITS-1:0] id_mem  [DEPTH];
   logic [XLEN-1:0]          res_mem [DEPTH];
   logic                     br_mem  [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow_q;
   logic             push;
   logic             pop;

   assign alu_ready_o = (count != FULL_COUNT);
   assign wb_valid_o  = (count != '0);
   assign push        = alu_valid_i && alu_ready_o && !flush_i;
   assign pop         = wb_valid_o && wb_ready_i && !flush_i;
   assign occupancy_o = count;
   assign overflow_o  = overflow_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // Sticky until reset; a flush does not clear it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_q <= 1'b0;
      end else if (alu_valid_i && !alu_ready_o) begin
         overflow_q <= 1'b1;
      end
   end

   // Storage needs no reset: entries are only observable while counted as valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         id_mem[wr_ptr]  <= alu_trans_id_i;
         res_mem[wr_ptr] <= alu_result_i;
         br_mem[wr_ptr]  <= alu_branch_res_i;
      end
   end

   always_comb begin
      wb_trans_id_o   = '0;
      wb_result_o     = '0;
      wb_branch_res_o = 1'b0;
      if (wb_valid_o) begin
         wb_trans_id_o   = id_mem[rd_ptr];
         wb_result_o     = res_mem[rd_ptr];
         wb_branch_res_o = br_mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_alu_wb_queue.sv
// Self-checking bench for alu_wb_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the result FIFO.
module tb_alu_wb_queue;

   localparam int XLEN  = 64;
   localparam int TID   = 3;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int EW    = TID + XLEN + 1;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            flush_i = 1'b0;
   logic            alu_valid_i = 1'b0;
   logic            alu_ready_o;
   logic [TID-1:0]  alu_trans_id_i = '0;
   logic [XLEN-1:0] alu_result_i = '0;
   logic            alu_branch_res_i = 1'b0;
   logic            wb_valid_o;
   logic            wb_ready_i = 1'b0;
   logic [TID-1:0]  wb_trans_id_o;
   logic [XLEN-1:0] wb_result_o;
   logic            wb_branch_res_o;
   logic [CW-1:0]   occupancy_o;
   logic            overflow_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: entries packed as {trans_id, result, branch_res}, head at index 0.
   logic [EW-1:0] exp_q[$];
   logic          exp_ovf = 1'b0;

   alu_wb_queue #(.XLEN(XLEN), .TRANS_ID_BITS(TID), .DEPTH(DEPTH)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .alu_valid_i      (alu_valid_i),
      .alu_ready_o      (alu_ready_o),
      .alu_trans_id_i   (alu_trans_id_i),
      .alu_result_i     (alu_result_i),
      .alu_branch_res_i (alu_branch_res_i),
      .wb_valid_o       (wb_valid_o),
      .wb_ready_i       (wb_ready_i),
      .wb_trans_id_o    (wb_trans_id_o),
      .wb_result_o      (wb_result_o),
      .wb_branch_res_o  (wb_branch_res_o),
      .occupancy_o      (occupancy_o),
      .overflow_o       (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [EW-1:0] head;
      head = '0;
      if (exp_q.size() != 0) head = exp_q[0];
      check("wb_valid",    64'(wb_valid_o),      64'(exp_q.size() != 0));
      check("wb_trans_id", 64'(wb_trans_id_o),   64'(head[EW-1 -: TID]));
      check("wb_result",   wb_result_o,          head[XLEN:1]);
      check("wb_branch",   64'(wb_branch_res_o), 64'(head[0]));
      check("occupancy",   64'(occupancy_o),     64'(exp_q.size()));
      check("alu_ready",   64'(alu_ready_o),     64'(exp_q.size() < DEPTH));
      check("overflow",    64'(overflow_o),      64'(exp_ovf));
   endtask

   // Called at a falling edge: drive inputs, check outputs, advance the model to
   // the state after the next rising edge, then wait for the following falling edge.
   task automatic cycle(input logic v, input logic [TID-1:0] id, input logic [XLEN-1:0] res,
                        input logic br, input logic rdy, input logic fl);
      bit full;
      bit empty;
      alu_valid_i      = v;
      alu_trans_id_i   = id;
      alu_result_i     = res;
      alu_branch_res_i = br;
      wb_ready_i       = rdy;
      flush_i          = fl;
      check_outputs();
      if (rst_ni) begin
         full  = (exp_q.size() == DEPTH);
         empty = (exp_q.size() == 0);
         if (v && full) exp_ovf = 1'b1;
         if (fl) begin
            exp_q.delete();
         end else begin
            if (rdy && !empty) void'(exp_q.pop_front());
            if (v && !full) exp_q.push_back({id, res, br});
         end
      end
      @(negedge clk_i);
   endtask

   function automatic logic [XLEN-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      @(negedge clk_i);
      idle(1'b0, 3);

      // Release reset and push in the same cycle; the first edge must accept it.
      rst_ni = 1'b1;
      cycle(1'b1, 3'd5, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1, 1'b0);
      idle(1'b1, 2);

      // Fill with backpressure, hold, then drain in order.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, TID'(i), rnd64(), 1'($urandom), 1'b0, 1'b0);
      idle(1'b0, 3);
      idle(1'b1, DEPTH + 1);

      // Simultaneous push and pop at occupancy 2 across pointer wraps.
      for (int i = 0; i < 2; i++) cycle(1'b1, TID'(i), rnd64(), 1'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b1, TID'(i + 2), rnd64(), 1'($urandom), 1'b1, 1'b0);
      idle(1'b1, 3);

      // Overflow: push ID 7 while full, then flush; flag must persist.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, TID'(i), rnd64(), 1'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 3'd7, rnd64(), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 3'd7, rnd64(), 1'b0, 1'b1, 1'b1);
      idle(1'b1, 2);

      // Flush at occupancy 3 with a concurrent push and pop.
      for (int i = 0; i < 3; i++) cycle(1'b1, TID'(i), rnd64(), 1'($urandom), 1'b0, 1'b0);
      cycle(1'b1, 3'd6, rnd64(), 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 3'd2, rnd64(), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 3'd3, rnd64(), 1'b1, 1'b1, 1'b0);
      idle(1'b1, 3);

      // Asynchronous reset mid-cycle at occupancy 2 (overflow is still set here).
      for (int i = 0; i < 2; i++) cycle(1'b1, TID'(i + 4), rnd64(), 1'($urandom), 1'b0, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      exp_q.delete();
      exp_ovf = 1'b0;
      check_outputs();
      @(negedge clk_i);
      idle(1'b1, 2);
      rst_ni = 1'b1;
      cycle(1'b1, 3'd4, rnd64(), 1'b1, 1'b0, 1'b0);
      idle(1'b1, 3);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 9) < 7), TID'($urandom), rnd64(), 1'($urandom),
               1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
      end
      idle(1'b1, DEPTH + 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_wb_queue.md
# alu_wb_queue

In-order result queue directly downstream of the integer ALU. Each cycle the ALU produces a result, a branch-compare bit and a transaction ID. This block captures them and presents them to the writeback/scoreboard port with a valid/ready handshake. It decouples ALU issue from writeback-port arbitration, supports pipeline flush, and flags protocol violations.

## Interface
Parameters:
- `XLEN`, 64, width of the ALU result.
- `TRANS_ID_BITS`, 3, scoreboard transaction-ID width.
- `DEPTH`, 4, number of queue entries. Must be a power of two and at least 2.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous flush: discard all queued and incoming results.
- `alu_valid_i`  in  1  ALU result valid this cycle.
- `alu_ready_o`  out  1  queue can accept a result this cycle.
- `alu_trans_id_i`  in  TRANS_ID_BITS  transaction ID of the incoming result.
- `alu_result_i`  in  XLEN  ALU result.
- `alu_branch_res_i`  in  1  ALU branch-compare result.
- `wb_valid_o`  out  1  head entry valid.
- `wb_ready_i`  in  1  writeback consumer accepts the head entry.
- `wb_trans_id_o`  out  TRANS_ID_BITS  head transaction ID.
- `wb_result_o`  out  XLEN  head result.
- `wb_branch_res_o`  out  1  head branch result.
- `occupancy_o`  out  $clog2(DEPTH)+1  number of valid entries.
- `overflow_o`  out  1  sticky error: a push was attempted while the queue was full.

## Operation
- Storage is a circular buffer of `DEPTH` entries. Each entry is {trans_id, result, branch_res}.
  - Write pointer, read pointer and count are registers.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH` with no special case.
- A push occurs when `alu_valid_i && alu_ready_o && !flush_i`. The entry is written at the write pointer, then the write pointer increments.
- A pop occurs when `wb_valid_o && wb_ready_i && !flush_i`. The read pointer increments.
- Count update:
  - push only: +1.
  - pop only: −1.
  - simultaneous push and pop: unchanged.
  - Count never exceeds `DEPTH` and never goes below 0.
- `alu_ready_o = (count != DEPTH)`. It depends only on registered state; there is no combinational path from `wb_ready_i`.
- A push attempted when full (`alu_valid_i && !alu_ready_o`) is dropped.
  - `overflow_o` is set on the next edge.
  - `overflow_o` stays high until reset; it is not cleared by flush.
- `wb_valid_o = (count != 0)`.
- When `wb_valid_o` is high, the `wb_*` data outputs show the entry at the read pointer.
- When `wb_valid_o` is low, `wb_trans_id_o`, `wb_result_o` and `wb_branch_res_o` are driven to 0.
- While `wb_valid_o && !wb_ready_i`, all `wb_*` outputs hold stable.
- `occupancy_o = count`.
- Flush: `flush_i` has priority over push and pop. On the next edge:
  - count and both pointers return to 0.
  - any push or pop in the flush cycle is discarded.
  - storage contents need not be cleared.
- Reset (asynchronous assert, any cycle including mid-transfer):
  - count, pointers and `overflow_o` go to 0.
  - Reset values: `wb_valid_o`=0, `wb_*` data=0, `alu_ready_o`=1, `occupancy_o`=0, `overflow_o`=0.
- Results leave in exactly the order they were accepted. No reordering or bypass.

## Timing
- Latency: a result pushed at edge N is visible with `wb_valid_o`=1 in the cycle after edge N. There is no same-cycle bypass from `alu_*_i` to `wb_*_o`.
- Throughput: one push and one pop per cycle sustained. A continuously ready consumer sees back-to-back valids.
- Full to not-full: after a pop at edge N, `alu_ready_o` rises in the cycle after edge N.
- Flush: asserted in cycle N, `wb_valid_o`=0 and `alu_ready_o`=1 in cycle N+1.
- Reset deassertion: the first push is accepted at the first rising edge after `rst_ni` goes high.

## Test plan
- Single result: push trans_id=5, result=64'hDEAD_BEEF_0000_0001, branch=1 with `wb_ready_i`=1.
  - Required: `wb_valid_o`=1 next cycle with identical fields.
  - Required: `occupancy_o` goes 1 then 0.
- Fill and backpressure: `DEPTH`=4, `wb_ready_i`=0, push IDs 0,1,2,3.
  - Required: `alu_ready_o`=0 after the 4th push.
  - Required: `occupancy_o`=4.
  - Required: head stays ID 0 and is stable.
  - Then raise `wb_ready_i`: required pops in order 0,1,2,3, and `alu_ready_o`=1 the cycle after the first pop.
- Simultaneous push and pop at occupancy 2: required occupancy stays 2, order is preserved, pointer wrap occurs correctly across 10 consecutive transfers.
- Overflow: when full, hold `alu_valid_i`=1 with ID 7.
  - Required: ID 7 never appears on `wb_trans_id_o`.
  - Required: `overflow_o`=1 next cycle and stays 1 after a flush.
- Flush with occupancy 3 plus a concurrent push and pop.
  - Required: next cycle `wb_valid_o`=0, `occupancy_o`=0, `wb_result_o`=0.
  - Required: the next pushed ID is the first popped.
- Reset mid-operation: assert `rst_ni`=0 asynchronously with occupancy 2.
  - Required: outputs immediately take the reset values `wb_valid_o`=0, `alu_ready_o`=1, `occupancy_o`=0, `overflow_o`=0.
  - Required: no stale entry after release.
